exp_output_stage_p: RTL and testbench

EXP_OUTPUT_STAGE_P -- requirements
Module: exp_output_stage_p

---
 rtl/exp_output_stage_p.sv | 99 +++++++++
 tb/tb_exp_output_stage_p.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_output_stage_p.sv
// exp_output_stage_p: 3-stage fixed-point product to IEEE-754 single converter
//   CLK, rst (async, active-low)
//   in_valid/in_ready             : operand handshake (FIXED_taylor_input, FIXED_e_input, exp_shift)
//   out_valid/out_ready           : result handshake (FLOAT_result_output, ovf, unf)
//   D_taylor_output               : upper FIX_W bits of the stage-1 product
module exp_output_stage_p #(
    parameter int FIX_W      = 26,
    parameter int EXP_W      = 9,
    parameter int ROUND_MODE = 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FIX_W-1:0] FIXED_taylor_input,
    input  logic [FIX_W-1:0] FIXED_e_input,
    input  logic [EXP_W-1:0] exp_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      FLOAT_result_output,
    output logic             ovf,
    output logic             unf,
    output logic [FIX_W-1:0] D_taylor_output
);
    localparam int PW = 2 * FIX_W;
    localparam int LW = $clog2(PW);
    localparam int XW = EXP_W + 3;
    localparam int NW = PW + 25;

    logic             en;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [PW-1:0]    p1_q, p1_d, n2_q, n2_d;
    logic [EXP_W-1:0] k1_q, k1_d;
    logic [XW-1:0]    e2_q, e2_d, b;
    logic [LW-1:0]    pos;
    logic [NW-1:0]    ext;
    logic [22:0]      man;
    logic             grd, stk;
    logic [23:0]      mr;
    logic [31:0]      res_q, res_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        en   = !v3_q || out_ready;
        v1_d = in_valid;
        v2_d = v1_q;
        v3_d = v2_q;
        k1_d = exp_shift;
        p1_d = PW'(FIXED_taylor_input) * PW'(FIXED_e_input);
        pos  = '0;
        for (int i = 0; i < PW; i++) pos = p1_q[i] ? LW'(i) : pos;
        // the leading one lands in the MSB; a zero product stays all-zero
        n2_d = p1_q << (LW'(PW - 1) - pos);
        e2_d = XW'(pos) - XW'(2 * (FIX_W - 2)) + XW'($signed(k1_q));
        // 25 zero bits on the right supply padding when the product is short
        ext  = {n2_q, 25'b0};
        man  = ext[NW-2 -: 23];
        grd  = ext[NW-25];
        stk  = |ext[NW-26:0];
        mr   = {1'b0, man} + 24'(ROUND_MODE == 1 && grd && (stk || man[0]));
        b    = e2_q + XW'(127) + XW'(mr[23]);
        ovf_d = ext[NW-1] && $signed(b) >= $signed(XW'(255));
        unf_d = ext[NW-1] && $signed(b) <= $signed(XW'(0));
        res_d = ovf_d ? 32'h7F80_0000 : (unf_d || !ext[NW-1]) ? 32'h0 : {1'b0, b[7:0], mr[22:0]};
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            p1_q  <= '0;
            k1_q  <= '0;
            n2_q  <= '0;
            e2_q  <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (en) begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            p1_q  <= p1_d;
            k1_q  <= k1_d;
            n2_q  <= n2_d;
            e2_q  <= e2_d;
            res_q <= res_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign in_ready            = en;
    assign out_valid           = v3_q;
    assign FLOAT_result_output = res_q;
    assign ovf                 = ovf_q;
    assign unf                 = unf_q;
    assign D_taylor_output     = p1_q[PW-1 -: FIX_W];
endmodule

// File: tb/tb_exp_output_stage_p.sv
// tb_exp_output_stage_p: vector table, directed corner cases and random scoreboard for exp_output_stage_p
module tb_exp_output_stage_p;
    typedef struct {
        logic [25:0] t;
        logic [25:0] e;
        logic [8:0]  k;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic [31:0] tres;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic [31:0] tres;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [25:0] tin, ein;
    logic [8:0]  kin;
    logic        in_ready, out_valid, ovf, unf;
    logic [31:0] res;
    logic [25:0] dtay;
    logic        tin_ready, tout_valid, tovf, tunf;
    logic [31:0] tres;
    logic [25:0] tdtay;

    int   total = 0, bad = 0, cyc = 0, pops = 0;
    bit   lat_chk = 1'b1, hold = 1'b0;
    logic [31:0] hres;
    logic [1:0]  hflags;
    exp_t expq[$];
    vec_t tbl[14];

    exp_output_stage_p dut (
        .CLK(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .FIXED_taylor_input(tin), .FIXED_e_input(ein), .exp_shift(kin),
        .out_valid(out_valid), .out_ready(out_ready), .FLOAT_result_output(res),
        .ovf(ovf), .unf(unf), .D_taylor_output(dtay)
    );

    exp_output_stage_p #(.ROUND_MODE(0)) dut_trunc (
        .CLK(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(tin_ready),
        .FIXED_taylor_input(tin), .FIXED_e_input(ein), .exp_shift(kin),
        .out_valid(tout_valid), .out_ready(out_ready), .FLOAT_result_output(tres),
        .ovf(tovf), .unf(tunf), .D_taylor_output(tdtay)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // value = t*e/2^48 * 2^k, rounded to 24 significant bits
    function automatic logic [33:0] model(input logic [25:0] t, input logic [25:0] e,
                                          input logic signed [8:0] k, input bit rne);
        longint unsigned p, m, rem, half;
        int msb, sh, b;
        p = 64'(t) * 64'(e);
        if (p == 0) return 34'd0;
        msb = $clog2(p + 1) - 1;
        if (msb > 23) begin
            sh   = msb - 23;
            m    = p >> sh;
            rem  = p - (m << sh);
            half = 64'd1 << (sh - 1);
            if (rne && (rem > half || (rem == half && m[0]))) m++;
        end else begin
            m = p << (23 - msb);
        end
        b = msb - 48 + int'(k) + 127;
        if (m == (64'd1 << 24)) begin
            m = m >> 1;
            b++;
        end
        if (b >= 255) return {2'b10, 32'h7F80_0000};
        if (b <= 0) return {2'b01, 32'h0};
        return {2'b00, 1'b0, 8'(b), m[22:0]};
    endfunction

    task automatic drive(input bit v, input vec_t x, output bit acc);
        in_valid = v;
        tin = x.t;
        ein = x.e;
        kin = x.k;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) expq.push_back('{x.res, x.ovf, x.unf, x.tres, cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t x);
        bit a;
        int n = 0;
        do begin
            drive(1'b1, x, a);
            n++;
        end while (!a && n < 100);
        if (!a) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (expq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 64'(expq.size()), 64'd0);
    endtask

    function automatic vec_t rnd_vec();
        vec_t x;
        logic [33:0] m, mt;
        x.t = ($urandom_range(0, 7) == 0) ? 26'd0 : 26'($urandom);
        x.e = ($urandom_range(0, 7) == 0) ? 26'h100_0000 : 26'($urandom);
        x.k = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'(int'($urandom_range(0, 60)) - 30);
        m  = model(x.t, x.e, x.k, 1'b1);
        mt = model(x.t, x.e, x.k, 1'b0);
        x.res  = m[31:0];
        x.ovf  = m[33];
        x.unf  = m[32];
        x.tres = mt[31:0];
        return x;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
                chk("trunc_valid", 64'(tout_valid), 64'(out_valid));
                if (hold) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_res", 64'(res), 64'(hres));
                    chk("hold_flags", 64'({ovf, unf}), 64'(hflags));
                end
                if (out_valid && out_ready) begin
                    pops++;
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %h expected none", res);
                    end else begin
                        e = expq.pop_front();
                        chk("result", 64'(res), 64'(e.res));
                        chk("ovf", 64'(ovf), 64'(e.ovf));
                        chk("unf", 64'(unf), 64'(e.unf));
                        chk("trunc_result", 64'(tres), 64'(e.tres));
                        if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'd3);
                    end
                end
                hold   = out_valid && !out_ready;
                hres   = res;
                hflags = {ovf, unf};
            end
        end
    endtask

    initial begin
        vec_t x;
        bit a;
        int p0, seen;
        tbl[0]  = '{26'h100_0000, 26'h100_0000, 9'd0,   32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000};
        tbl[1]  = '{26'h100_0000, 26'h100_0000, 9'd1,   32'h4000_0000, 1'b0, 1'b0, 32'h4000_0000};
        tbl[2]  = '{26'h180_0000, 26'h200_0000, 9'd0,   32'h4040_0000, 1'b0, 1'b0, 32'h4040_0000};
        tbl[3]  = '{26'h100_0003, 26'h100_0000, 9'd0,   32'h3F80_0002, 1'b0, 1'b0, 32'h3F80_0001};
        tbl[4]  = '{26'h100_0001, 26'h100_0000, 9'd0,   32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000};
        tbl[5]  = '{26'h100_0000, 26'h100_0000, 9'd200, 32'h7F80_0000, 1'b1, 1'b0, 32'h7F80_0000};
        tbl[6]  = '{26'h100_0000, 26'h100_0000, 9'h181, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};
        tbl[7]  = '{26'h000_0000, 26'h100_0000, 9'd200, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
        tbl[8]  = '{26'h100_0000, 26'h000_0000, 9'h100, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
        tbl[9]  = '{26'h3FF_FFFF, 26'h3FF_FFFF, 9'd0,   32'h4180_0000, 1'b0, 1'b0, 32'h417F_FFFF};
        tbl[10] = '{26'h3FF_FFFF, 26'h3FF_FFFF, 9'd124, 32'h7F80_0000, 1'b1, 1'b0, 32'h7F7F_FFFF};
        tbl[11] = '{26'h100_0000, 26'h100_0000, 9'h182, 32'h0080_0000, 1'b0, 1'b0, 32'h0080_0000};
        tbl[12] = '{26'h100_0000, 26'h100_0000, 9'd127, 32'h7F00_0000, 1'b0, 1'b0, 32'h7F00_0000};
        tbl[13] = '{26'h000_0001, 26'h000_0001, 9'd0,   32'h2780_0000, 1'b0, 1'b0, 32'h2780_0000};
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tin = '0;
        ein = '0;
        kin = '0;
        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
        join_none
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(res), 64'd0);
        chk("rst_flags", 64'({ovf, unf}), 64'd0);
        chk("rst_dtaylor", 64'(dtay), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        fork
            monitor();
        join_none

        send(tbl[0]);
        in_valid = 1'b0;
        chk("dtaylor", 64'(dtay), 64'h40_0000);
        drain();

        for (int i = 0; i < 14; i++) send(tbl[i]);
        drain();

        for (int i = 0; i < 60; i++) begin
            x = rnd_vec();
            drive($urandom_range(0, 3) != 0, x, a);
        end
        drain();

        lat_chk = 1'b0;
        for (int i = 0; i < 80; i++) begin
            x = rnd_vec();
            out_ready = $urandom_range(0, 2) != 0;
            drive($urandom_range(0, 3) != 0, x, a);
        end
        out_ready = 1'b1;
        drain();

        p0 = pops;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            for (int i = 9; i < 14; i++) send(tbl[i]);
        join
        drain();
        chk("bp_count", 64'(pops - p0), 64'd5);
        lat_chk = 1'b1;

        send(tbl[0]);
        send(tbl[2]);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result", 64'(res), 64'd0);
        chk("mid_rst_flags", 64'({ovf, unf}), 64'd0);
        chk("mid_rst_dtaylor", 64'(dtay), 64'd0);
        expq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_stale", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        send(tbl[3]);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
